// File: rtl/hwpe_arb_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_arb_pkg
// Shared definitions for the EAI ICB two-requester arbiter:
//   - arbiter FSM state encoding
//   - requester ID constants carried in the outstanding-ID FIFO
//   - err_src codes and a helper that maps a requester ID to its bus-error code
// -----------------------------------------------------------------------------
package hwpe_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic ID_R0 = 1'b0;
  localparam logic ID_R1 = 1'b1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_R0   = 2'b01;
  localparam logic [1:0] ERR_R1   = 2'b10;
  localparam logic [1:0] ERR_SPUR = 2'b11;

  // Bus-error code for the requester that issued the failing command.
  function automatic logic [1:0] bus_err_code(input logic id);
    logic [1:0] code;
    if (id == ID_R1) begin
      code = ERR_R1;
    end else begin
      code = ERR_R0;
    end
    return code;
  endfunction

endpackage

// File: rtl/eai_icb_id_fifo.sv
// -----------------------------------------------------------------------------
// eai_icb_id_fifo
// 1-bit wide FIFO holding the requester ID of every outstanding ICB command,
// in issue order. The head entry identifies who owns the next response.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears to empty)
//   i_push      write i_push_id at the tail
//   i_push_id   requester ID to store
//   i_pop       drop the head entry
//   o_full      DEPTH entries stored
//   o_empty     nothing stored
//   o_head      ID at the head (valid only when !o_empty)
// -----------------------------------------------------------------------------
module eai_icb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_push_id,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == (AW+1)'(0));
  assign o_head  = r_mem[r_rd_ptr];

  // Pop is ignored when empty; a push while full is only taken if the head
  // leaves in the same cycle, so the occupancy can never overflow.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eai_icb_arb.sv
// -----------------------------------------------------------------------------
// eai_icb_arb
// Round-robin arbiter with burst locking in front of the single EAI ICB port.
//   r0_* : ReLU accumulator writeback stream (requester 0)
//   r1_* : fmap/kernel load engine (requester 1)
//   eai_icb_* : master side toward the memory port
//   busy      : arbiter owns the port or responses are still outstanding
//   err_pulse : one-cycle registered flag, err_src says why
//               (01 r0 bus error, 10 r1 bus error, 11 spurious response)
// Each accepted command pushes its requester ID into an ID FIFO; the head ID
// steers the next response back to the requester that issued it.
// Only valid/ready are steered; rdata/err fan out to both requesters.
// -----------------------------------------------------------------------------
module eai_icb_arb
  import hwpe_arb_pkg::*;
#(
  parameter int OUTS_DEPTH = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        r0_cmd_valid,
  output logic        r0_cmd_ready,
  input  logic [31:0] r0_cmd_addr,
  input  logic        r0_cmd_read,
  input  logic [31:0] r0_cmd_wdata,
  input  logic [3:0]  r0_cmd_wmask,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_rsp_rdata,
  output logic        r0_rsp_err,

  input  logic        r1_cmd_valid,
  output logic        r1_cmd_ready,
  input  logic [31:0] r1_cmd_addr,
  input  logic        r1_cmd_read,
  input  logic [31:0] r1_cmd_wdata,
  input  logic [3:0]  r1_cmd_wmask,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_rsp_rdata,
  output logic        r1_rsp_err,

  output logic        eai_icb_cmd_valid,
  input  logic        eai_icb_cmd_ready,
  output logic [31:0] eai_icb_cmd_addr,
  output logic        eai_icb_cmd_read,
  output logic [31:0] eai_icb_cmd_wdata,
  output logic [3:0]  eai_icb_cmd_wmask,
  input  logic        eai_icb_rsp_valid,
  output logic        eai_icb_rsp_ready,
  input  logic [31:0] eai_icb_rsp_rdata,
  input  logic        eai_icb_rsp_err,

  output logic        busy,
  output logic        err_pulse,
  output logic [1:0]  err_src
);

  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          r_last_owner;
  logic [CW-1:0] r_burst_cnt;
  logic          r_err_pulse;
  logic [1:0]    r_err_src;

  logic          w_leave;
  logic          w_cmd_hs;
  logic          w_rsp_hs;
  logic          w_spurious;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_fifo_head;
  logic          w_burst_end;

  // --------------------------------------------------------------------------
  // Outstanding-ID FIFO
  // --------------------------------------------------------------------------
  eai_icb_id_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_cmd_hs),
    .i_push_id ((r_state == ST_OWN1) ? ID_R1 : ID_R0),
    .i_pop     (w_rsp_hs),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_head    (w_fifo_head)
  );

  // --------------------------------------------------------------------------
  // Command side
  // --------------------------------------------------------------------------
  assign w_cmd_hs    = eai_icb_cmd_valid & eai_icb_cmd_ready;
  assign w_burst_end = w_cmd_hs & (r_burst_cnt == BURST_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. IDLE never grants in the same cycle; ties go to the
  // requester that did not own the port last. The burst limit only forces a
  // hand-over when the other requester is actually waiting.
  always_comb begin
    w_state_nxt = r_state;
    w_leave     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r0_cmd_valid & r1_cmd_valid) begin
          w_state_nxt = (r_last_owner == ID_R1) ? ST_OWN0 : ST_OWN1;
        end else if (r0_cmd_valid) begin
          w_state_nxt = ST_OWN0;
        end else if (r1_cmd_valid) begin
          w_state_nxt = ST_OWN1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (~r0_cmd_valid | (w_burst_end & r1_cmd_valid)) begin
          w_leave     = 1'b1;
          w_state_nxt = r1_cmd_valid ? ST_OWN1 : ST_IDLE;
        end else begin
          w_state_nxt = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (~r1_cmd_valid | (w_burst_end & r0_cmd_valid)) begin
          w_leave     = 1'b1;
          w_state_nxt = r0_cmd_valid ? ST_OWN0 : ST_IDLE;
        end else begin
          w_state_nxt = ST_OWN1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command mux and ready steering. Full is a registered condition, so a pop
  // this cycle cannot open the command path until the next one.
  always_comb begin
    eai_icb_cmd_valid = 1'b0;
    eai_icb_cmd_addr  = r0_cmd_addr;
    eai_icb_cmd_read  = r0_cmd_read;
    eai_icb_cmd_wdata = r0_cmd_wdata;
    eai_icb_cmd_wmask = r0_cmd_wmask;
    r0_cmd_ready      = 1'b0;
    r1_cmd_ready      = 1'b0;
    case (r_state)
      ST_OWN0: begin
        eai_icb_cmd_valid = r0_cmd_valid & ~w_fifo_full;
        r0_cmd_ready      = eai_icb_cmd_ready & ~w_fifo_full;
      end
      ST_OWN1: begin
        eai_icb_cmd_addr  = r1_cmd_addr;
        eai_icb_cmd_read  = r1_cmd_read;
        eai_icb_cmd_wdata = r1_cmd_wdata;
        eai_icb_cmd_wmask = r1_cmd_wmask;
        eai_icb_cmd_valid = r1_cmd_valid & ~w_fifo_full;
        r1_cmd_ready      = eai_icb_cmd_ready & ~w_fifo_full;
      end
      default: begin
        eai_icb_cmd_valid = 1'b0;
      end
    endcase
  end

  // Burst counter and round-robin history. The counter saturates so an
  // uncontested owner keeps streaming without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= ID_R1;
      r_burst_cnt  <= '0;
    end else if (w_leave) begin
      r_last_owner <= (r_state == ST_OWN1) ? ID_R1 : ID_R0;
      r_burst_cnt  <= '0;
    end else if (w_cmd_hs & (r_burst_cnt != BURST_LAST)) begin
      r_burst_cnt  <= r_burst_cnt + CW'(1);
    end else begin
      r_burst_cnt  <= r_burst_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Response side
  // --------------------------------------------------------------------------
  assign w_spurious = eai_icb_rsp_valid & w_fifo_empty;
  assign w_rsp_hs   = eai_icb_rsp_valid & eai_icb_rsp_ready & ~w_fifo_empty;

  assign r0_rsp_rdata = eai_icb_rsp_rdata;
  assign r1_rsp_rdata = eai_icb_rsp_rdata;
  assign r0_rsp_err   = eai_icb_rsp_err;
  assign r1_rsp_err   = eai_icb_rsp_err;

  // Steer valid/ready by the head ID; with nothing outstanding, any response
  // is accepted and dropped so the bus cannot lock up.
  always_comb begin
    r0_rsp_valid      = 1'b0;
    r1_rsp_valid      = 1'b0;
    eai_icb_rsp_ready = 1'b0;
    if (w_fifo_empty) begin
      eai_icb_rsp_ready = eai_icb_rsp_valid;
    end else if (w_fifo_head == ID_R1) begin
      r1_rsp_valid      = eai_icb_rsp_valid;
      eai_icb_rsp_ready = r1_rsp_ready;
    end else begin
      r0_rsp_valid      = eai_icb_rsp_valid;
      eai_icb_rsp_ready = r0_rsp_ready;
    end
  end

  // Registered error reporting: spurious responses take precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_src   <= ERR_NONE;
    end else if (w_spurious) begin
      r_err_pulse <= 1'b1;
      r_err_src   <= ERR_SPUR;
    end else if (w_rsp_hs & eai_icb_rsp_err) begin
      r_err_pulse <= 1'b1;
      r_err_src   <= bus_err_code(w_fifo_head);
    end else begin
      r_err_pulse <= 1'b0;
      r_err_src   <= ERR_NONE;
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_src   = r_err_src;
  assign busy      = (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule

// File: tb/tb_eai_icb_arb.sv
// -----------------------------------------------------------------------------
// tb_eai_icb_arb
// Directed bench for eai_icb_arb. Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_eai_icb_arb;

  logic        clk;
  logic        rst;
  logic        r0_cmd_valid, r0_cmd_ready, r0_cmd_read;
  logic [31:0] r0_cmd_addr, r0_cmd_wdata;
  logic [3:0]  r0_cmd_wmask;
  logic        r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic [31:0] r0_rsp_rdata;
  logic        r1_cmd_valid, r1_cmd_ready, r1_cmd_read;
  logic [31:0] r1_cmd_addr, r1_cmd_wdata;
  logic [3:0]  r1_cmd_wmask;
  logic        r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [31:0] r1_rsp_rdata;
  logic        eai_icb_cmd_valid, eai_icb_cmd_ready, eai_icb_cmd_read;
  logic [31:0] eai_icb_cmd_addr, eai_icb_cmd_wdata;
  logic [3:0]  eai_icb_cmd_wmask;
  logic        eai_icb_rsp_valid, eai_icb_rsp_ready, eai_icb_rsp_err;
  logic [31:0] eai_icb_rsp_rdata;
  logic        busy, err_pulse;
  logic [1:0]  err_src;

  // Master-side responder: either driven by hand or automatically answering
  // every command the bench has seen accepted.
  logic        auto_rsp;
  logic        man_rsp_valid;
  int          outst;
  int          n_chk;
  int          n_pass;

  assign eai_icb_rsp_valid = auto_rsp ? (outst != 0) : man_rsp_valid;

  eai_icb_arb #(.OUTS_DEPTH(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_addr(r0_cmd_addr),
    .r0_cmd_read(r0_cmd_read), .r0_cmd_wdata(r0_cmd_wdata), .r0_cmd_wmask(r0_cmd_wmask),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_rdata(r0_rsp_rdata),
    .r0_rsp_err(r0_rsp_err),
    .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_addr(r1_cmd_addr),
    .r1_cmd_read(r1_cmd_read), .r1_cmd_wdata(r1_cmd_wdata), .r1_cmd_wmask(r1_cmd_wmask),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_rdata(r1_rsp_rdata),
    .r1_rsp_err(r1_rsp_err),
    .eai_icb_cmd_valid(eai_icb_cmd_valid), .eai_icb_cmd_ready(eai_icb_cmd_ready),
    .eai_icb_cmd_addr(eai_icb_cmd_addr), .eai_icb_cmd_read(eai_icb_cmd_read),
    .eai_icb_cmd_wdata(eai_icb_cmd_wdata), .eai_icb_cmd_wmask(eai_icb_cmd_wmask),
    .eai_icb_rsp_valid(eai_icb_rsp_valid), .eai_icb_rsp_ready(eai_icb_rsp_ready),
    .eai_icb_rsp_rdata(eai_icb_rsp_rdata), .eai_icb_rsp_err(eai_icb_rsp_err),
    .busy(busy), .err_pulse(err_pulse), .err_src(err_src)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count commands accepted by the master minus responses consumed.
  always @(posedge clk) begin
    if (rst) begin
      outst <= 0;
    end else begin
      outst <= outst + ((eai_icb_cmd_valid && eai_icb_cmd_ready) ? 1 : 0)
                     - ((eai_icb_rsp_valid && eai_icb_rsp_ready && outst > 0) ? 1 : 0);
    end
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic [1:0]  who;
    logic [1:0]  exp_who;
    int          acc;

    n_chk = 0; n_pass = 0;
    auto_rsp = 1'b0; man_rsp_valid = 1'b0;
    r0_cmd_valid = 1'b0; r0_cmd_addr = 32'h0; r0_cmd_read = 1'b0;
    r0_cmd_wdata = 32'h0; r0_cmd_wmask = 4'hF; r0_rsp_ready = 1'b1;
    r1_cmd_valid = 1'b0; r1_cmd_addr = 32'h0; r1_cmd_read = 1'b1;
    r1_cmd_wdata = 32'h0; r1_cmd_wmask = 4'hF; r1_rsp_ready = 1'b1;
    eai_icb_cmd_ready = 1'b1; eai_icb_rsp_rdata = 32'h0; eai_icb_rsp_err = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_valid", {31'd0, eai_icb_cmd_valid}, 32'd0);
    chk("rst_rsp_ready", {31'd0, eai_icb_rsp_ready}, 32'd0);
    chk("rst_err", {29'd0, err_pulse, err_src}, 32'd0);

    // ---------------- r0 alone, 3 writes ----------------
    addrs[0] = 32'h100; addrs[1] = 32'h108; addrs[2] = 32'h110;
    r0_cmd_valid = 1'b1; r0_cmd_addr = addrs[0]; r0_cmd_wdata = 32'hA5;
    #1;
    chk("idle_no_grant", {31'd0, r0_cmd_ready}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      r0_cmd_addr = addrs[i];
      #1;
      chk("t1_cmd_valid", {31'd0, eai_icb_cmd_valid}, 32'd1);
      chk("t1_cmd_ready", {31'd0, r0_cmd_ready}, 32'd1);
      chk("t1_cmd_addr", eai_icb_cmd_addr, addrs[i]);
      chk("t1_cmd_read", {31'd0, eai_icb_cmd_read}, 32'd0);
      tick();
    end
    r0_cmd_valid = 1'b0;
    #1;
    chk("t1_busy_own", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_outst", {31'd0, busy}, 32'd1);
    man_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eai_icb_rsp_rdata = 32'h1000 + i;
      #1;
      chk("t1_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd1);
      chk("t1_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
      chk("t1_r0_rdata", r0_rsp_rdata, 32'h1000 + i);
      chk("t1_busy_rsp", {31'd0, busy}, 32'd1);
      tick();
    end
    man_rsp_valid = 1'b0;
    #1;
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    chk("t1_no_err", {29'd0, err_pulse, err_src}, 32'd0);

    // ---------------- both valid: r0 first, 8/8 bursts ----------------
    do_reset();
    auto_rsp = 1'b1;
    r0_cmd_valid = 1'b1; r1_cmd_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      #1;
      who = {r1_cmd_valid & r1_cmd_ready, r0_cmd_valid & r0_cmd_ready};
      if (c == 0) exp_who = 2'b00;
      else if (c <= 8) exp_who = 2'b01;
      else if (c <= 16) exp_who = 2'b10;
      else exp_who = 2'b01;
      chk($sformatf("t2_grant_c%0d", c), {30'd0, who}, {30'd0, exp_who});
      tick();
    end
    r0_cmd_valid = 1'b0; r1_cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    auto_rsp = 1'b0;
    #1;
    chk("t2_drained", {31'd0, busy}, 32'd0);

    // ---------------- r1 reads with responses held off ----------------
    do_reset();
    r1_cmd_valid = 1'b1; r1_cmd_addr = 32'h2000;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (r1_cmd_ready) acc++;
      tick();
    end
    chk("t3_accepted", acc, 32'd4);
    #1;
    chk("t3_full_stall", {31'd0, r1_cmd_ready}, 32'd0);
    chk("t3_full_master", {31'd0, eai_icb_cmd_valid}, 32'd0);
    man_rsp_valid = 1'b1;
    #1;
    chk("t3_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd1);
    chk("t3_same_cycle_block", {31'd0, r1_cmd_ready}, 32'd0);
    tick();
    man_rsp_valid = 1'b0;
    #1;
    chk("t3_unblock", {31'd0, r1_cmd_ready}, 32'd1);
    tick();
    r1_cmd_valid = 1'b0;
    auto_rsp = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    auto_rsp = 1'b0;
    #1;
    chk("t3_drained", {31'd0, busy}, 32'd0);

    // ---------------- interleaved r0 write / r1 read, r1 bus error ----------------
    r0_cmd_valid = 1'b1; r0_cmd_addr = 32'h300;
    tick();
    #1;
    chk("t4_r0_grant", {31'd0, r0_cmd_ready}, 32'd1);
    tick();
    r0_cmd_valid = 1'b0; r1_cmd_valid = 1'b1; r1_cmd_addr = 32'h400;
    tick();
    #1;
    chk("t4_r1_grant", {31'd0, r1_cmd_ready}, 32'd1);
    chk("t4_r1_addr", eai_icb_cmd_addr, 32'h400);
    tick();
    r1_cmd_valid = 1'b0;
    man_rsp_valid = 1'b1; eai_icb_rsp_rdata = 32'h11; eai_icb_rsp_err = 1'b0;
    #1;
    chk("t4_r0_rsp", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd1);
    chk("t4_r0_err", {31'd0, r0_rsp_err}, 32'd0);
    tick();
    eai_icb_rsp_rdata = 32'h22; eai_icb_rsp_err = 1'b1;
    #1;
    chk("t4_no_err_after_r0", {29'd0, err_pulse, err_src}, 32'd0);
    chk("t4_r1_rsp", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd2);
    chk("t4_r1_err", {31'd0, r1_rsp_err}, 32'd1);
    chk("t4_r1_rdata", r1_rsp_rdata, 32'h22);
    tick();
    man_rsp_valid = 1'b0; eai_icb_rsp_err = 1'b0;
    #1;
    chk("t4_err_r1", {29'd0, err_pulse, err_src}, {29'd0, 1'b1, 2'b10});
    tick();
    chk("t4_err_clear", {29'd0, err_pulse, err_src}, 32'd0);

    // ---------------- spurious response ----------------
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    man_rsp_valid = 1'b1;
    #1;
    chk("t5_drop_ready", {31'd0, eai_icb_rsp_ready}, 32'd1);
    chk("t5_no_rsp_valid", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
    tick();
    man_rsp_valid = 1'b0;
    #1;
    chk("t5_err_spur", {29'd0, err_pulse, err_src}, {29'd0, 1'b1, 2'b11});
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    tick();

    // ---------------- reset mid-burst with 2 outstanding ----------------
    r0_cmd_valid = 1'b1; r0_cmd_addr = 32'h500;
    tick();
    tick();
    tick();
    #1;
    chk("t6_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; r0_cmd_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_cmd_valid", {31'd0, eai_icb_cmd_valid}, 32'd0);
    man_rsp_valid = 1'b1;
    #1;
    chk("t6_stale_drop", {31'd0, eai_icb_rsp_ready}, 32'd1);
    chk("t6_stale_no_route", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
    tick();
    man_rsp_valid = 1'b0;
    #1;
    chk("t6_stale_spur", {29'd0, err_pulse, err_src}, {29'd0, 1'b1, 2'b11});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eai_icb_arb.md
Name: eai_icb_arb

Overview:
Two-requester arbiter for the single EAI ICB memory port.
- Requester 0: ReLU accumulator-register writeback stream.
- Requester 1: fmap/kernel load engine (reads).
- Grants the port round-robin with burst locking. Tracks outstanding commands in an ID FIFO and routes each ICB response back to its issuer. Flags bus errors and spurious responses.

Parameters:
- OUTS_DEPTH, 4, max outstanding ICB commands (power of 2, >=2)
- BURST_MAX, 8, max consecutive command handshakes granted to one requester while the other is waiting

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r0_cmd_valid  in  1  requester 0 command valid
- r0_cmd_ready  out  1  requester 0 command accepted
- r0_cmd_addr  in  32  requester 0 address
- r0_cmd_read  in  1  requester 0 read=1/write=0
- r0_cmd_wdata  in  32  requester 0 write data
- r0_cmd_wmask  in  4  requester 0 byte mask
- r0_rsp_valid  out  1  response for requester 0
- r0_rsp_ready  in  1  requester 0 response accept
- r0_rsp_rdata  out  32  read data
- r0_rsp_err  out  1  bus error
- r1_cmd_valid, r1_cmd_ready, r1_cmd_addr, r1_cmd_read, r1_cmd_wdata, r1_cmd_wmask, r1_rsp_valid, r1_rsp_ready, r1_rsp_rdata, r1_rsp_err: same as r0_*, for requester 1
- eai_icb_cmd_valid  out  1  master command valid
- eai_icb_cmd_ready  in  1  master command ready
- eai_icb_cmd_addr  out  32
- eai_icb_cmd_read  out  1
- eai_icb_cmd_wdata  out  32
- eai_icb_cmd_wmask  out  4
- eai_icb_rsp_valid  in  1
- eai_icb_rsp_ready  out  1
- eai_icb_rsp_rdata  in  32
- eai_icb_rsp_err  in  1
- busy  out  1  state!=IDLE or outstanding FIFO non-empty
- err_pulse  out  1  one-cycle registered error flag
- err_src  out  2  01=r0 bus err, 10=r1 bus err, 11=spurious rsp, 00=none

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registers: last_owner (reset 1, so r0 wins first tie), burst_cnt (reset 0), ID FIFO (reset empty).
- IDLE:
  - any valid -> OWNx next cycle.
  - Both valid -> the requester != last_owner.
  - No grant is given in IDLE itself; one cycle arbitration latency.
- OWNx:
  - Master cmd mux selects rx.
  - eai_icb_cmd_valid = rx_cmd_valid & ~fifo_full.
  - rx_cmd_ready = eai_icb_cmd_ready & ~fifo_full.
  - Non-owner cmd_ready = 0.
  - On each handshake: push ID x into the FIFO and increment burst_cnt.
- Leave OWNx when rx_cmd_valid=0, or when burst_cnt==BURST_MAX-1 at a handshake and the other requester is valid.
  - If the other requester is valid: go directly to OWN(other).
  - Otherwise: go to IDLE.
  - On leaving: last_owner<=x, burst_cnt<=0.
- Burst limit ignored if the other requester is idle; burst_cnt saturates at BURST_MAX-1.
- Full FIFO blocks commands. Pop in the same cycle does not unblock until the next cycle (no ready path through rsp).
- Response routing:
  - head ID h selects the target.
  - rh_rsp_valid = eai_icb_rsp_valid & ~fifo_empty.
  - eai_icb_rsp_ready = rh_rsp_ready when non-empty.
  - rdata/err are passed through to both requesters; only valid/ready are steered.
  - Pop on response handshake.
  - Simultaneous push+pop: count unchanged, both take effect.
- Spurious response (rsp_valid while FIFO empty): eai_icb_rsp_ready=1 (drop), err_pulse=1, err_src=11 next cycle.
- Bus error: response handshake with eai_icb_rsp_err=1 -> err_pulse=1, err_src=01/10 per head ID next cycle. Otherwise err_pulse=0, err_src=00.
- Reset mid-operation: FSM IDLE, FIFO cleared, in-flight responses after reset are treated as spurious.
- Outputs at reset: all cmd_ready/rsp_valid=0, eai_icb_cmd_valid=0, eai_icb_rsp_ready=0, busy=0, err_pulse=0, err_src=00, master data outputs driven from r0 mux (don't-care).
- Combinational paths: master ready->requester ready, requester valid->master valid only. No path from rsp inputs into the cmd side.

Decomposition:
- Shared package hwpe_arb_pkg: FSM state encodings, requester ID constants (ID_R0=0, ID_R1=1), err_src codes.
- One sub-module: eai_icb_id_fifo. 1-bit wide, OUTS_DEPTH deep, synchronous reset, push/pop/full/empty/head, simultaneous push+pop when full or empty handled.

Test Plan:
- Reset then r0 alone issues 3 writes (addr 0x100, 0x108, 0x110), master ready=1 -> r0 grant after 1 cycle, 3 master cmds in order, busy=1 until 3 rsps return to r0 only.
- r0 and r1 valid together from IDLE -> r0 first. With both held valid, r0 gets exactly 8 handshakes, then r1 gets 8, alternating.
- Master rsp held off, r1 issues 5 reads -> 4 accepted, 5th stalls (r1_cmd_ready=0) until first rsp handshake. Then accepted next cycle.
- Interleaved r0 write/r1 read outstanding, responses returned in order with rsp_err=1 on the r1 one -> r1_rsp_err=1, err_pulse=1 with err_src=10 one cycle later. r0 rsp unaffected.
- eai_icb_rsp_valid=1 with FIFO empty -> eai_icb_rsp_ready=1, no requester rsp_valid, err_src=11 pulse.
- rst asserted mid-burst with 2 outstanding -> next cycle IDLE, busy=0, subsequent stale rsp flagged spurious.
